// File: rtl/wb_select_if.sv
// wb_select_if: writeback request, load response and register-write bundle
interface wb_select_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_sel;
  logic            in_regwrite;
  logic [REGW-1:0] in_rd;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  logic [XLEN-1:0] in_alu_res;
  logic [XLEN-1:0] in_pc_plus4;
  logic [XLEN-1:0] in_imm;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            rf_we;
  logic [REGW-1:0] rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            err;
  modport master (
    output in_valid, in_sel, in_regwrite, in_rd, in_funct3, in_addr_lo,
           in_alu_res, in_pc_plus4, in_imm, mem_rsp_valid, mem_rsp_data,
    input  in_ready, rf_we, rf_rd, rf_wdata, err
  );
  modport slave (
    input  in_valid, in_sel, in_regwrite, in_rd, in_funct3, in_addr_lo,
           in_alu_res, in_pc_plus4, in_imm, mem_rsp_valid, mem_rsp_data,
    output in_ready, rf_we, rf_rd, rf_wdata, err
  );
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered writeback source select with load wait, extension and timeout
module wb_select_stage #(
  parameter int XLEN        = 32,
  parameter int REGW        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst,
  wb_select_if.slave bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t          state;
  logic [REGW-1:0] rd_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      alo_q;
  logic [CW-1:0]   cnt;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [XLEN-1:0] ld;
  logic [XLEN-1:0] src;
  logic            bad;
  logic            wr_now;
  logic            wr_ld;
  assign bus.in_ready = (state == IDLE);
  assign wr_now = bus.in_regwrite && (bus.in_rd != '0);
  assign wr_ld  = we_q && (rd_q != '0);
  // little-endian sub-word extraction, extension and legality of the pending load
  always_comb begin
    b   = bus.mem_rsp_data[{alo_q, 3'b000} +: 8];
    h   = alo_q[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
    ld  = f3_q == 3'b000 ? {{(XLEN-8){b[7]}}, b} :
          f3_q == 3'b001 ? {{(XLEN-16){h[15]}}, h} :
          f3_q == 3'b100 ? {{(XLEN-8){1'b0}}, b} :
          f3_q == 3'b101 ? {{(XLEN-16){1'b0}}, h} : bus.mem_rsp_data;
    bad = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11) ||
          (f3_q[1:0] == 2'b01 && alo_q[0]) || (f3_q == 3'b010 && alo_q != 2'b00);
    src = bus.in_sel == 2'b00 ? bus.in_alu_res :
          bus.in_sel == 2'b10 ? bus.in_pc_plus4 : bus.in_imm;
  end
  // accept requests, wait for load data or timeout, drive single-cycle write/err pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.rf_we    <= 1'b0;
      bus.rf_rd    <= '0;
      bus.rf_wdata <= '0;
      bus.err      <= 1'b0;
      cnt          <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      alo_q        <= '0;
    end else begin
      bus.rf_we <= 1'b0;
      bus.err   <= 1'b0;
      if (state == IDLE) begin
        if (bus.in_valid && bus.in_sel == 2'b01) begin
          state <= WAIT_MEM;
          cnt   <= '0;
          rd_q  <= bus.in_rd;
          we_q  <= bus.in_regwrite;
          f3_q  <= bus.in_funct3;
          alo_q <= bus.in_addr_lo;
        end else if (bus.in_valid) begin
          bus.rf_we <= wr_now;
          if (wr_now) begin
            bus.rf_rd    <= bus.in_rd;
            bus.rf_wdata <= src;
          end
        end
      end else if (bus.mem_rsp_valid) begin
        state     <= IDLE;
        bus.err   <= bad;
        bus.rf_we <= !bad && wr_ld;
        if (!bad && wr_ld) begin
          bus.rf_rd    <= rd_q;
          bus.rf_wdata <= ld;
        end
      end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
        state   <= IDLE;
        bus.err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
